// File: rtl/qspi_target_pkg.sv
// qspi_target_pkg: shared states, command codes and helpers for the QSPI RAM target
package qspi_target_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WRITE, READ, IGNORE} qspi_target_state_e;
  localparam logic [7:0] QSPI_CMD_WRITE = 8'h02;
  localparam logic [7:0] QSPI_CMD_READ = 8'h0B;
  localparam int QSPI_DUMMY_CYCLES = 2;
  function automatic logic cmd_known(input logic [7:0] c);
    return c == QSPI_CMD_WRITE || c == QSPI_CMD_READ;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with rising/falling edge pulses
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clock or negedge reset)
    if (!reset) {s1, s2, s3} <= {3{RST_VAL}};
    else {s1, s2, s3} <= {din, s1, s2};
  assign level = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/qspi_ram_target.sv
// qspi_ram_target: quad-SPI responder emulating a small byte-addressed RAM
module qspi_ram_target
  import qspi_target_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_clk_in,
  input  logic       spi_select,
  input  logic [3:0] spi_data_in,
  output logic [3:0] spi_data_out,
  output logic [3:0] spi_data_oe,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  qspi_target_state_e state, state_nx;
  logic sck_lvl, sck_rise, sck_fall, sel_n, sel_rise, sel_fall, we;
  logic [3:0] d1, d2, hi;
  logic [1:0] nib;
  logic [7:0] cmd;
  logic [11:0] sh;
  logic [AW-1:0] addr;
  logic [7:0] mem [DEPTH];
  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clock(clock), .reset(reset), .din(spi_clk_in),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  // Select sync resets to "asserted" so a select held low through reset never looks like a new frame
  spi_sync_edge #(.RST_VAL(1'b0)) u_sel (
    .clock(clock), .reset(reset), .din(spi_select),
    .level(sel_n), .rise(sel_rise), .fall(sel_fall)
  );
  always_comb begin
    state_nx = state;
    if (sel_n) state_nx = IDLE;
    else if (state == IDLE) state_nx = (sel_fall && !sck_lvl) ? CMD : IDLE;
    else if (sck_rise)
      case (state)
        CMD: if (nib[0]) state_nx = cmd_known({sh[3:0], d2}) ? ADDR : IGNORE;
        ADDR: if (nib == 2'd3) state_nx = (cmd == QSPI_CMD_WRITE) ? WRITE : DUMMY;
        DUMMY: if (nib == 2'(QSPI_DUMMY_CYCLES - 1)) state_nx = READ;
        default: ;
      endcase
  end
  assign we = state == WRITE && !sel_n && sck_rise && nib[0];
  assign spi_data_oe = {4{state == READ}};
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      nib <= '0;
      cmd <= '0;
      sh <= '0;
      hi <= '0;
      addr <= '0;
      d1 <= '0;
      d2 <= '0;
      spi_data_out <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      d1 <= spi_data_in;
      d2 <= d1;
      busy <= sel_fall ? 1'b1 : sel_rise ? 1'b0 : busy;
      nib <= (state_nx != state) ? 2'd0 : nib + 2'((state == READ) ? sck_fall : sck_rise);
      if (sck_rise && (state == CMD || state == ADDR)) sh <= {sh[7:0], d2};
      if (sck_rise && state == CMD && nib[0]) cmd <= {sh[3:0], d2};
      if (sck_rise && state == ADDR && nib == 2'd3) addr <= AW'({sh, d2});
      if (sck_rise && state == WRITE) begin
        if (!nib[0]) hi <= d2;
        else addr <= addr + AW'(1);
      end
      if (sck_fall && state == READ) begin
        spi_data_out <= nib[0] ? mem[addr][3:0] : mem[addr][7:4];
        if (nib[0]) addr <= addr + AW'(1);
      end
      if (sel_n) spi_data_out <= '0;
    end
  always_ff @(posedge clock)
    if (we) mem[addr] <= {hi, d2};
endmodule

// File: tb/tb_qspi_ram_target.sv
// tb_qspi_ram_target: randomized QSPI host against a flat byte-array memory model
module tb_qspi_ram_target;
  localparam int DEPTH = 64;
  localparam int HALF = 5;
  logic clock = 1'b0, reset = 1'b0, spi_clk_in = 1'b0, spi_select = 1'b1;
  logic [3:0] spi_data_in = 4'h0;
  logic [3:0] spi_data_out, spi_data_oe;
  logic busy;
  int n_chk = 0, n_pass = 0;
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] wq [$];

  always #5 clock = ~clock;

  qspi_ram_target #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .spi_clk_in(spi_clk_in), .spi_select(spi_select),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One SCK cycle: data set while low, host samples target output just before the rise
  task automatic xfer(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    spi_data_in = d;
    repeat (HALF) @(negedge clock);
    q = spi_data_out;
    oe = spi_data_oe;
    spi_clk_in = 1'b1;
    repeat (HALF) @(negedge clock);
    spi_clk_in = 1'b0;
  endtask

  task automatic open_frame(input logic [7:0] c, input logic [15:0] a, output logic [3:0] oe_or);
    logic [3:0] q, oe;
    logic [23:0] w;
    w = {c, a};
    oe_or = 4'h0;
    spi_select = 1'b0;
    repeat (HALF) @(negedge clock);
    check("busy_open", busy, 1);
    for (int i = 5; i >= 0; i--) begin
      xfer(w[i*4 +: 4], q, oe);
      oe_or |= oe;
    end
  endtask

  task automatic close_frame();
    spi_select = 1'b1;
    repeat (10) @(negedge clock);
    check("busy_close", busy, 0);
    check("oe_close", spi_data_oe, 0);
  endtask

  task automatic do_write(input logic [15:0] a);
    logic [3:0] q, oe, oe_or;
    open_frame(8'h02, a, oe_or);
    foreach (wq[i]) begin
      xfer(wq[i][7:4], q, oe);
      oe_or |= oe;
      xfer(wq[i][3:0], q, oe);
      oe_or |= oe;
      ref_mem[(int'(a) + i) % DEPTH] = wq[i];
    end
    close_frame();
    check("write_oe", oe_or, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [3:0] qh, ql, oe, oe_or, oe_and;
    int idx;
    open_frame(8'h0B, a, oe_or);
    for (int i = 0; i < 2; i++) begin
      xfer($urandom, qh, oe);
      oe_or |= oe;
    end
    check("dummy_oe", oe_or, 0);
    oe_and = 4'hF;
    for (int i = 0; i < n; i++) begin
      xfer(4'h0, qh, oe);
      oe_and &= oe;
      xfer(4'h0, ql, oe);
      oe_and &= oe;
      idx = (int'(a) + i) % DEPTH;
      check($sformatf("rd[%0d]", idx), {qh, ql}, ref_mem[idx]);
    end
    check("read_oe", oe_and, 4'hF);
    close_frame();
  endtask

  initial begin
    logic [3:0] q, oe, acc;
    repeat (3) @(negedge clock);
    check("rst_dout", spi_data_out, 0);
    check("rst_oe", spi_data_oe, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("post_rst_busy", busy, 0);
    // Fill every location so all later reads have a defined expectation
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(8'($urandom));
    do_write(16'h0000);
    do_read(16'h0000, DEPTH);
    wq = '{8'hA5, 8'h3C};
    do_write(16'h0005);
    do_read(16'h0005, 2);
    wq = '{8'h11, 8'h22};
    do_write(16'h003F);
    do_read(16'h003F, 2);
    wq = '{8'h77};
    do_write(16'h1243);
    do_read(16'h0003, 1);
    // Unknown command: must neither write nor drive
    spi_select = 1'b0;
    repeat (HALF) @(negedge clock);
    acc = 4'h0;
    xfer(4'h9, q, oe);
    acc |= oe;
    xfer(4'hF, q, oe);
    acc |= oe;
    for (int i = 0; i < 6; i++) begin
      xfer($urandom, q, oe);
      acc |= oe | q;
    end
    close_frame();
    check("ignore_oe", acc, 0);
    do_read(16'h0000, DEPTH);
    // Half byte then deselect: location 8 untouched
    open_frame(8'h02, 16'h0008, acc);
    xfer(~ref_mem[8][7:4], q, oe);
    close_frame();
    do_read(16'h0008, 1);
    for (int k = 0; k < 20; k++) begin
      wq.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) wq.push_back(8'($urandom));
      do_write(16'($urandom));
      do_read(16'($urandom), $urandom_range(1, 8));
    end
    // Reset in the middle of a read data phase
    wq = '{8'hFF, 8'hEE};
    do_write(16'h0010);
    open_frame(8'h0B, 16'h0010, acc);
    xfer(4'h0, q, oe);
    xfer(4'h0, q, oe);
    xfer(4'h0, q, oe);
    check("pre_rst_oe", spi_data_oe, 4'hF);
    check("pre_rst_dout", spi_data_out, 4'hF);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_dout", spi_data_out, 0);
    check("midrst_oe", spi_data_oe, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    acc = 4'h0;
    for (int i = 0; i < 8; i++) begin
      xfer(i[0] ? 4'hB : 4'h0, q, oe);
      acc |= oe | q;
    end
    check("held_sel_quiet", acc, 0);
    check("held_sel_busy", busy, 0);
    close_frame();
    do_read(16'h0010, 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
